// File: rtl/perf_counter_unit.sv
// Performance event counters for the PL_CPU pipeline: saturating cycle/stall/branch counters
// with a run/halt sequencer and a registered request/acknowledge read port.
module perf_counter_unit #(
    parameter int CNT_WIDTH = 32,
    parameter int SEL_WIDTH = 3
) (
    input  logic                 input_clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 hlt,
    input  logic                 stall,
    input  logic                 bp_valid,
    input  logic                 bp_miss,
    input  logic                 rd_req,
    input  logic [SEL_WIDTH-1:0] rd_sel,
    output logic                 rd_ack,
    output logic [CNT_WIDTH-1:0] rd_data,
    output logic                 running,
    output logic                 halted
);

    // state  | meaning
    // IDLE   | waiting for en, nothing counted
    // RUN    | counting every cycle in which hlt is low
    // HALT   | counts frozen until clr
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam int N_CNT = 4;

    state_t               r_state;
    logic                 r_running;
    logic                 r_halted;
    logic [CNT_WIDTH-1:0] r_cnt [N_CNT];
    logic [N_CNT-1:0]     r_ovf;
    logic                 r_rd_ack;
    logic [CNT_WIDTH-1:0] r_rd_data;

    logic                 w_count_en;
    logic [N_CNT-1:0]     w_inc;
    logic                 w_rd_accept;
    logic [CNT_WIDTH-1:0] w_executed;
    logic [CNT_WIDTH-1:0] w_status;
    logic [CNT_WIDTH-1:0] w_sel_value;

    always_ff @(posedge input_clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
            r_halted  <= 1'b0;
        end else if (clr) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (en) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (hlt) begin
                        r_state   <= ST_HALT;
                        r_running <= 1'b0;
                        r_halted  <= 1'b1;
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_running <= 1'b0;
                    r_halted  <= 1'b0;
                end
            endcase
        end
    end

    // The retiring halt itself is excluded, so a halted count matches the last RUN cycle.
    assign w_count_en = (r_state == ST_RUN) && !hlt;
    assign w_inc      = {bp_valid & bp_miss, bp_valid, stall, 1'b1};

    always_ff @(posedge input_clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_CNT; i++) r_cnt[i] <= '0;
            r_ovf <= '0;
        end else if (clr) begin
            for (int i = 0; i < N_CNT; i++) r_cnt[i] <= '0;
            r_ovf <= '0;
        end else if (w_count_en) begin
            for (int i = 0; i < N_CNT; i++) begin
                if (w_inc[i]) begin
                    if (&r_cnt[i]) r_ovf[i] <= 1'b1;
                    else           r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign w_executed = r_cnt[0] - r_cnt[1];
    // Narrow builds keep only the low bits of the status word.
    assign w_status   = CNT_WIDTH'({r_ovf, r_halted, r_running});

    always_comb begin
        w_sel_value = '0;
        case (rd_sel)
            SEL_WIDTH'(0): w_sel_value = r_cnt[0];
            SEL_WIDTH'(1): w_sel_value = r_cnt[1];
            SEL_WIDTH'(2): w_sel_value = r_cnt[2];
            SEL_WIDTH'(3): w_sel_value = r_cnt[3];
            SEL_WIDTH'(4): w_sel_value = w_executed;
            SEL_WIDTH'(5): w_sel_value = w_status;
            default:       w_sel_value = '0;
        endcase
    end

    // Read path ignores clr so a read accepted alongside clr returns the pre-clear value.
    assign w_rd_accept = rd_req && !r_rd_ack;

    always_ff @(posedge input_clk or negedge rst) begin
        if (!rst) begin
            r_rd_ack  <= 1'b0;
            r_rd_data <= '0;
        end else if (w_rd_accept) begin
            r_rd_ack  <= 1'b1;
            r_rd_data <= w_sel_value;
        end else begin
            r_rd_ack  <= 1'b0;
        end
    end

    assign rd_ack  = r_rd_ack;
    assign rd_data = r_rd_data;
    assign running = r_running;
    assign halted  = r_halted;

endmodule

// File: tb/tb_perf_counter_unit.sv
// Directed bench for perf_counter_unit: a 32-bit and a 4-bit instance share stimulus.
module tb_perf_counter_unit;

    logic        input_clk;
    logic        rst;
    logic        en, clr, hlt, stall, bp_valid, bp_miss, rd_req;
    logic [2:0]  rd_sel;
    logic        rd_ack, running, halted;
    logic [31:0] rd_data;
    logic        rd_ack4, running4, halted4;
    logic [3:0]  rd_data4;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] rq;
    logic [31:0] rq4;
    int          n_ack;
    logic [9:0]  stall_v, bpv_v, miss_v;

    perf_counter_unit #(.CNT_WIDTH(32), .SEL_WIDTH(3)) u_dut (
        .input_clk(input_clk), .rst(rst), .en(en), .clr(clr), .hlt(hlt),
        .stall(stall), .bp_valid(bp_valid), .bp_miss(bp_miss),
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_ack(rd_ack), .rd_data(rd_data),
        .running(running), .halted(halted)
    );

    perf_counter_unit #(.CNT_WIDTH(4), .SEL_WIDTH(3)) u_dut4 (
        .input_clk(input_clk), .rst(rst), .en(en), .clr(clr), .hlt(hlt),
        .stall(stall), .bp_valid(bp_valid), .bp_miss(bp_miss),
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_ack(rd_ack4), .rd_data(rd_data4),
        .running(running4), .halted(halted4)
    );

    initial input_clk = 1'b0;
    always #5 input_clk = ~input_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge input_clk);
        #1;
    endtask

    // Two edges: acceptance, then the ack cycle; result left in rq/rq4.
    task automatic do_read(input logic [2:0] sel);
        rd_req = 1'b1;
        rd_sel = sel;
        step();
        rd_req = 1'b0;
        chk("rd_ack", {31'd0, rd_ack}, 32'd1);
        chk("rd_ack4", {31'd0, rd_ack4}, 32'd1);
        rq  = rd_data;
        rq4 = {28'd0, rd_data4};
        step();
    endtask

    initial begin
        en = 0; clr = 0; hlt = 0; stall = 0; bp_valid = 0; bp_miss = 0;
        rd_req = 0; rd_sel = 3'd0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        chk("rst_ack", {31'd0, rd_ack}, 32'd0);
        chk("rst_data", rd_data, 32'd0);
        chk("rst_running", {31'd0, running}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        #5 rst = 1'b1;

        // Basic run: 10 cycles, stalls on 3,4; bp pulses on 1,2,5,6,7,8; miss on 2,6; stray miss on 9.
        stall_v = 10'b0000001100;
        bpv_v   = 10'b0011110011;
        miss_v  = 10'b0100100010;
        en = 1'b1;
        step();
        en = 1'b0;
        chk("run_running", {31'd0, running}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            stall    = stall_v[i];
            bp_valid = bpv_v[i];
            bp_miss  = miss_v[i];
            step();
        end
        stall = 0; bp_valid = 0; bp_miss = 0;
        hlt = 1'b1;
        stall = 1'b1; bp_valid = 1'b1;
        step();
        hlt = 1'b0;
        chk("hlt_halted", {31'd0, halted}, 32'd1);
        chk("hlt_running", {31'd0, running}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            stall = 1'b1; bp_valid = 1'b1; bp_miss = 1'b1;
            step();
        end
        stall = 0; bp_valid = 0; bp_miss = 0;
        do_read(3'd0); chk("sel0_cycle", rq, 32'd10); chk("sel0_cycle4", rq4, 32'd10);
        do_read(3'd1); chk("sel1_stall", rq, 32'd2);
        do_read(3'd2); chk("sel2_bp", rq, 32'd6);
        do_read(3'd3); chk("sel3_miss", rq, 32'd2);
        do_read(3'd4); chk("sel4_exec", rq, 32'd8);
        do_read(3'd5); chk("sel5_status", rq, 32'd2); chk("sel5_status4", rq4, 32'd2);
        do_read(3'd6); chk("sel6_zero", rq, 32'd0);

        // Read accepted in a counting cycle returns the pre-increment value.
        clr = 1'b1; step(); clr = 1'b0;
        en = 1'b1; step(); en = 1'b0;
        for (int i = 0; i < 5; i++) step();
        rd_req = 1'b1; rd_sel = 3'd0;
        step();
        rd_req = 1'b0;
        chk("live_ack", {31'd0, rd_ack}, 32'd1);
        chk("live_data", rd_data, 32'd5);
        step();
        chk("live_ack_drop", {31'd0, rd_ack}, 32'd0);
        n_ack = 0;
        rd_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (rd_ack) n_ack++;
        end
        rd_req = 1'b0;
        step();
        chk("held_req_acks", n_ack, 32'd3);

        // Saturation: 18 counted cycles; the 4-bit build sticks at 15 with ovf[0].
        clr = 1'b1; step(); clr = 1'b0;
        en = 1'b1; step(); en = 1'b0;
        for (int i = 0; i < 18; i++) step();
        do_read(3'd0); chk("sat_cnt32", rq, 32'd18); chk("sat_cnt4", rq4, 32'd15);
        do_read(3'd5); chk("sat_status32", rq, 32'd1); chk("sat_status4", rq4, 32'd5);
        chk("sat_running4", {31'd0, running4}, 32'd1);

        // clr during HALT together with a read: old value returned, then everything cleared.
        hlt = 1'b1; step(); hlt = 1'b0;
        chk("halt2_halted", {31'd0, halted}, 32'd1);
        clr = 1'b1; rd_req = 1'b1; rd_sel = 3'd0;
        step();
        clr = 1'b0; rd_req = 1'b0;
        chk("clr_rd_ack", {31'd0, rd_ack}, 32'd1);
        chk("clr_rd_old", rd_data, 32'd22);
        chk("clr_rd_old4", {28'd0, rd_data4}, 32'd15);
        step();
        do_read(3'd0); chk("clr_cnt", rq, 32'd0); chk("clr_cnt4", rq4, 32'd0);
        do_read(3'd5); chk("clr_status", rq, 32'd0); chk("clr_status4", rq4, 32'd0);

        // Async reset mid-RUN while an ack is showing.
        en = 1'b1; step(); en = 1'b0;
        for (int i = 0; i < 3; i++) step();
        rd_req = 1'b1; rd_sel = 3'd0;
        step();
        rd_req = 1'b0;
        chk("pre_rst_ack", {31'd0, rd_ack}, 32'd1);
        chk("pre_rst_data", rd_data, 32'd3);
        #2 rst = 1'b0;
        #1;
        chk("arst_ack", {31'd0, rd_ack}, 32'd0);
        chk("arst_data", rd_data, 32'd0);
        chk("arst_running", {31'd0, running}, 32'd0);
        #1 rst = 1'b1;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) step();
        stall = 1'b0;
        do_read(3'd0); chk("post_rst_cnt", rq, 32'd0);
        chk("post_rst_running", {31'd0, running}, 32'd0);
        en = 1'b1; step(); en = 1'b0;
        chk("reen_running", {31'd0, running}, 32'd1);
        do_read(3'd0); chk("reen_cnt", rq, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
